bus_uart: RTL and testbench

Memory-mapped UART slave on the simple request/acknowledge bus that the AXI3 slave bridge drives, sitting directly downstream of it. It accepts one-cycle request pulses with address, write data and byte strobes, answers each with a one-cycle acknowledge carrying read data and an error flag, and serialises/deserialises 8N1 frames through 16-entry TX and RX FIFOs. It is the console path for the terminal.

---
 rtl/bus_uart_pkg.sv | 29 ++
 rtl/uart_fifo.sv | 45 ++++
 rtl/bus_uart.sv | 268 ++++++++++++++++++++++++++
 tb/tb_bus_uart.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_uart_pkg.sv
// bus_uart shared definitions: register offsets,
// STATUS bit positions and serial FSM encodings.
package bus_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int ST_RXNE   = 0;
    localparam int ST_TXFULL = 1;
    localparam int ST_TXIDLE = 2;
    localparam int ST_OVR    = 3;
    localparam int ST_FE     = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte-wide synchronous FIFO with show-ahead output.
// Extra pointer bit separates full from empty at wrap.
module uart_fifo #(
    parameter int DEPTHLOG = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    logic [7:0]        mem [2**DEPTHLOG];
    logic [DEPTHLOG:0] wptr;
    logic [DEPTHLOG:0] rptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[DEPTHLOG] != rptr[DEPTHLOG]) &&
                     (wptr[DEPTHLOG-1:0] == rptr[DEPTHLOG-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[DEPTHLOG-1:0]];

    // advance pointers on accepted push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (DEPTHLOG+1)'(1);
            if (do_pop)  rptr <= rptr + (DEPTHLOG+1)'(1);
        end
    end

    // storage array, contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[DEPTHLOG-1:0]] <= din;
    end

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART slave with 16-deep TX/RX FIFOs
// on the request/acknowledge bus; console path.
module bus_uart
    import bus_uart_pkg::*;
#(
    parameter logic [15:0] DIV      = 16'd868,
    parameter int          DEPTHLOG = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        busreq,
    input  logic [31:0] busaddr,
    input  logic        buswr,
    input  logic [31:0] buswdata,
    input  logic [3:0]  buswstrb,
    output logic [31:0] busrdata,
    output logic        busack,
    output logic        buserr,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);

    logic [1:0]  rsel;
    logic        rd_req, wr_req;
    logic [15:0] divr;
    logic        ovr, fe;
    logic        set_ovr, set_fe, clr_ovr, clr_fe;
    logic [31:0] status;
    logic [31:0] rdata_d;
    logic        err_d;

    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_dout;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_dout;

    tx_state_t   tx_state, tx_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_tick, txidle;

    rx_state_t   rx_state, rx_next;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_wait;
    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_tick, rx_fall, rx_stop_ok;

    logic        unused;
    assign unused = ^{busaddr[31:4], busaddr[1:0],
                      buswdata[31:16], buswstrb[3:2]};

    assign rsel    = busaddr[3:2];
    assign rd_req  = busreq && !buswr;
    assign wr_req  = busreq && buswr;
    assign tx_push = wr_req && rsel == REG_DATA && buswstrb[0];
    assign rx_pop  = rd_req && rsel == REG_DATA;
    assign clr_ovr = wr_req && rsel == REG_STATUS &&
                     buswstrb[0] && buswdata[ST_OVR];
    assign clr_fe  = wr_req && rsel == REG_STATUS &&
                     buswstrb[0] && buswdata[ST_FE];
    assign txidle  = tx_empty && tx_state == TX_IDLE;
    assign tx_tick = (tx_cnt == 16'd0);
    assign rx_tick = (rx_cnt == 16'd0);
    assign rx_fall = rx_prev && !rx_s2;

    uart_fifo #(.DEPTHLOG(DEPTHLOG)) u_txf (
        .clk(clk), .rst(rst),
        .push(tx_push), .pop(tx_pop),
        .din(buswdata[7:0]), .dout(tx_dout),
        .full(tx_full), .empty(tx_empty)
    );

    uart_fifo #(.DEPTHLOG(DEPTHLOG)) u_rxf (
        .clk(clk), .rst(rst),
        .push(rx_push), .pop(rx_pop),
        .din(rx_sh), .dout(rx_dout),
        .full(rx_full), .empty(rx_empty)
    );

    // assemble STATUS and decode the bus response
    always_comb begin
        status            = '0;
        status[ST_RXNE]   = !rx_empty;
        status[ST_TXFULL] = tx_full;
        status[ST_TXIDLE] = txidle;
        status[ST_OVR]    = ovr;
        status[ST_FE]     = fe;
        rdata_d           = '0;
        err_d             = 1'b0;
        if (busreq) begin
            case (rsel)
                REG_DATA: begin
                    if (!buswr)
                        rdata_d = rx_empty ? 32'h8000_0000
                                           : {24'd0, rx_dout};
                    else
                        err_d = buswstrb[0] && tx_full;
                end
                REG_STATUS: if (!buswr) rdata_d = status;
                REG_DIV:    if (!buswr) rdata_d = {16'd0, divr};
                default:    err_d = 1'b1;
            endcase
        end
    end

    // one-cycle acknowledge with registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            busack   <= 1'b0;
            busrdata <= '0;
            buserr   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            busack   <= busreq;
            busrdata <= rdata_d;
            buserr   <= err_d;
            irq      <= !rx_empty;
        end
    end

    // divisor register and sticky error flags, set beats clear
    always_ff @(posedge clk) begin
        if (rst) begin
            divr <= DIV;
            ovr  <= 1'b0;
            fe   <= 1'b0;
        end else begin
            if (wr_req && rsel == REG_DIV) begin
                if (buswstrb[0]) divr[7:0]  <= buswdata[7:0];
                if (buswstrb[1]) divr[15:8] <= buswdata[15:8];
            end
            ovr <= (ovr && !clr_ovr) || set_ovr;
            fe  <= (fe && !clr_fe) || set_fe;
        end
    end

    // TX state register
    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    // TX bit timer and shifter, timer reloads at each boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
        end else if (tx_state == TX_IDLE) begin
            if (!tx_empty) begin
                tx_sh  <= tx_dout;
                tx_cnt <= divr;
                tx_bit <= '0;
            end
        end else if (tx_tick) begin
            tx_cnt <= divr;
            if (tx_state == TX_DATA) begin
                tx_sh  <= tx_sh >> 1;
                tx_bit <= tx_bit + 3'd1;
            end
        end else begin
            tx_cnt <= tx_cnt - 16'd1;
        end
    end

    // TX next state
    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            TX_IDLE:  if (!tx_empty) tx_next = TX_START;
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
        endcase
    end

    // TX outputs: line level and FIFO pop
    always_comb begin
        tx_pop = (tx_state == TX_IDLE) && !tx_empty;
        unique case (tx_state)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = tx_sh[0];
            default:  tx = 1'b1;
        endcase
    end

    // two-flop synchroniser plus edge history for rx
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    // RX mid-bit timer, shifter and break-wait flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            rx_wait <= 1'b0;
        end else begin
            unique case (rx_state)
                RX_IDLE: begin
                    rx_wait <= 1'b0;
                    if (rx_fall) rx_cnt <= divr >> 1;
                end
                RX_START, RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= divr;
                        if (rx_state == RX_START) begin
                            rx_bit <= '0;
                        end else begin
                            rx_sh  <= {rx_s2, rx_sh[7:1]};
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_wait) begin
                        if (rx_s2) rx_wait <= 1'b0;
                    end else if (rx_tick) begin
                        if (!rx_s2) rx_wait <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // RX next state
    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if ((rx_wait || rx_tick) && rx_s2) rx_next = RX_IDLE;
        endcase
    end

    // RX outputs: push good byte, flag overrun or framing
    always_comb begin
        rx_stop_ok = (rx_state == RX_STOP) && !rx_wait && rx_tick;
        rx_push    = rx_stop_ok && rx_s2 && !rx_full;
        set_ovr    = rx_stop_ok && rx_s2 && rx_full;
        set_fe     = rx_stop_ok && !rx_s2;
    end

endmodule

// File: tb/tb_bus_uart.sv
// Self-checking bench for bus_uart: register table,
// TX waveform, loopback, FIFO full, framing and overrun.
`timescale 1ns/1ps
module tb_bus_uart;
    import bus_uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        busreq;
    logic [31:0] busaddr;
    logic        buswr;
    logic [31:0] buswdata;
    logic [3:0]  buswstrb;
    logic [31:0] busrdata;
    logic        busack;
    logic        buserr;
    logic        tx;
    logic        rx;
    logic        irq;
    logic        loop;
    logic        rx_drv;

    always #5 clk = ~clk;

    assign rx = loop ? tx : rx_drv;

    bus_uart dut (
        .clk(clk), .rst(rst),
        .busreq(busreq), .busaddr(busaddr), .buswr(buswr),
        .buswdata(buswdata), .buswstrb(buswstrb),
        .busrdata(busrdata), .busack(busack), .buserr(buserr),
        .tx(tx), .rx(rx), .irq(irq)
    );

    typedef struct {
        logic [1:0]  off;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vt[13];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic bus(input string name, input logic [1:0] off,
                       input logic wr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] erd,
                       input logic eerr);
        exp_t e;
        @(posedge clk); #1;
        check({name, " idle ack"}, 32'(busack), 32'd0);
        check({name, " idle rdata"}, busrdata, 32'd0);
        busreq   = 1'b1;
        busaddr  = {28'd0, off, 2'b00};
        buswr    = wr;
        buswdata = wd;
        buswstrb = st;
        e.rd  = erd;
        e.err = eerr;
        sb.push_back(e);
        @(posedge clk); #1;
        busreq   = 1'b0;
        buswr    = 1'b0;
        buswdata = '0;
        buswstrb = '0;
        check({name, " ack"}, 32'(busack), 32'd1);
        for (int i = 0; i < 8 && !busack; i++) begin
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        if (busack) begin
            check({name, " rdata"}, busrdata, e.rd);
            check({name, " err"}, 32'(buserr), 32'(e.err));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst    = 1'b1;
        busreq = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            rx_drv = f[k];
            repeat (16) @(posedge clk);
            #1;
        end
        if (!stopb) begin
            repeat (16) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
        repeat (16) @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] fr;
        logic [7:0] bytes [17];
        int         n;

        vt[0]  = '{2'd1, 1'b0, 32'h0,         4'h0, 32'h0000_0004, 1'b0};
        vt[1]  = '{2'd2, 1'b0, 32'h0,         4'h0, 32'd868,       1'b0};
        vt[2]  = '{2'd3, 1'b0, 32'h0,         4'h0, 32'h0,         1'b1};
        vt[3]  = '{2'd3, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
        vt[4]  = '{2'd2, 1'b1, 32'h0000_1234, 4'h2, 32'h0,         1'b0};
        vt[5]  = '{2'd2, 1'b0, 32'h0,         4'h0, 32'h0000_1264, 1'b0};
        vt[6]  = '{2'd2, 1'b1, 32'hABCD_000F, 4'hF, 32'h0,         1'b0};
        vt[7]  = '{2'd2, 1'b0, 32'h0,         4'h0, 32'h0000_000F, 1'b0};
        vt[8]  = '{2'd0, 1'b0, 32'h0,         4'h0, 32'h8000_0000, 1'b0};
        vt[9]  = '{2'd1, 1'b1, 32'h0000_0018, 4'h1, 32'h0,         1'b0};
        vt[10] = '{2'd1, 1'b0, 32'h0,         4'h0, 32'h0000_0004, 1'b0};
        vt[11] = '{2'd0, 1'b1, 32'h0000_0055, 4'h0, 32'h0,         1'b0};
        vt[12] = '{2'd1, 1'b0, 32'h0,         4'h0, 32'h0000_0004, 1'b0};

        rst      = 1'b1;
        busreq   = 1'b0;
        busaddr  = '0;
        buswr    = 1'b0;
        buswdata = '0;
        buswstrb = '0;
        loop     = 1'b0;
        rx_drv   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset tx", 32'(tx), 32'd1);
        check("reset busack", 32'(busack), 32'd0);
        check("reset buserr", 32'(buserr), 32'd0);
        check("reset busrdata", busrdata, 32'd0);
        check("reset irq", 32'(irq), 32'd0);

        for (int i = 0; i < 13; i++)
            bus($sformatf("vec%0d", i), vt[i].off, vt[i].wr,
                vt[i].wd, vt[i].st, vt[i].erd, vt[i].eerr);

        // TX waveform, DIV already 15
        bus("tx A5", REG_DATA, 1'b1, 32'h0000_00A5, 4'h1, 32'h0, 1'b0);
        check("tx before start", 32'(tx), 32'd1);
        fr = {1'b1, 8'hA5, 1'b0};
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx bit%0d first", k), 32'(tx), 32'(fr[k]));
            repeat (15) @(posedge clk);
            #1;
            check($sformatf("tx bit%0d last", k), 32'(tx), 32'(fr[k]));
            @(posedge clk); #1;
        end
        check("tx idle after", 32'(tx), 32'd1);
        bus("txidle stat", REG_STATUS, 1'b0, 32'h0, 4'h0, 32'h4, 1'b0);

        // loopback
        loop = 1'b1;
        bus("loop wr", REG_DATA, 1'b1, 32'h0000_003C, 4'h1, 32'h0, 1'b0);
        check("irq low in frame", 32'(irq), 32'd0);
        n = 0;
        while (!irq && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("irq rise", 32'(irq), 32'd1);
        check("irq after frame", 32'(n >= 150), 32'd1);
        bus("loop rd", REG_DATA, 1'b0, 32'h0, 4'h0, 32'h0000_003C, 1'b0);
        bus("loop rd2", REG_DATA, 1'b0, 32'h0, 4'h0, 32'h8000_0000, 1'b0);
        check("irq clear", 32'(irq), 32'd0);
        loop = 1'b0;

        // TX FIFO fill, then reset mid-frame
        do_reset();
        bus("div1000", REG_DIV, 1'b1, 32'd1000, 4'h3, 32'h0, 1'b0);
        for (int i = 0; i < 17; i++)
            bus($sformatf("fill%0d", i), REG_DATA, 1'b1, 32'h0,
                4'h1, 32'h0, 1'b0);
        bus("fill17", REG_DATA, 1'b1, 32'h0, 4'h1, 32'h0, 1'b1);
        bus("full stat", REG_STATUS, 1'b0, 32'h0, 4'h0, 32'h2, 1'b0);
        check("tx mid frame", 32'(tx), 32'd0);
        do_reset();
        check("tx after reset", 32'(tx), 32'd1);
        bus("rst stat", REG_STATUS, 1'b0, 32'h0, 4'h0, 32'h4, 1'b0);
        bus("rst div", REG_DIV, 1'b0, 32'h0, 4'h0, 32'd868, 1'b0);
        bus("div15", REG_DIV, 1'b1, 32'd15, 4'h3, 32'h0, 1'b0);

        // framing error
        send_rx(8'h5A, 1'b0);
        bus("fe stat", REG_STATUS, 1'b0, 32'h0, 4'h0, 32'h14, 1'b0);
        check("fe irq", 32'(irq), 32'd0);
        bus("fe clr", REG_STATUS, 1'b1, 32'h10, 4'h1, 32'h0, 1'b0);
        bus("fe stat2", REG_STATUS, 1'b0, 32'h0, 4'h0, 32'h4, 1'b0);

        // RX overrun
        for (int i = 0; i < 17; i++) begin
            bytes[i] = 8'(i * 13 + 7);
            send_rx(bytes[i], 1'b1);
        end
        bus("ovr stat", REG_STATUS, 1'b0, 32'h0, 4'h0, 32'h0D, 1'b0);
        check("ovr irq", 32'(irq), 32'd1);
        for (int i = 0; i < 16; i++)
            bus($sformatf("drain%0d", i), REG_DATA, 1'b0, 32'h0, 4'h0,
                {24'd0, bytes[i]}, 1'b0);
        bus("drain empty", REG_DATA, 1'b0, 32'h0, 4'h0, 32'h8000_0000, 1'b0);
        bus("off3 rd", 2'd3, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        check("irq drained", 32'(irq), 32'd0);
        bus("ovr clr", REG_STATUS, 1'b1, 32'h08, 4'h1, 32'h0, 1'b0);
        bus("ovr stat2", REG_STATUS, 1'b0, 32'h0, 4'h0, 32'h4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
